// File: rtl/rw_instr_mem_pipe.sv
// Read/write instruction memory with byte-enabled writes, a pipelined read path
// (write-first bypass), a misalignment flag and a NOP-fill clear engine.
module rw_instr_mem_pipe #(
    parameter int unsigned SIZE_BYTES   = 1024,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] FILL_WORD    = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        read_req_i,
    input  logic [31:0] read_addr_i,
    output logic        read_ready_o,
    output logic [31:0] read_data_o,
    output logic        read_valid_o,
    output logic        read_misalign_o,
    input  logic        write_enable_i,
    input  logic [31:0] write_addr_i,
    input  logic [31:0] write_data_i,
    input  logic [3:0]  write_be_i,
    input  logic        clear_req_i,
    output logic        busy_o
);

    localparam int unsigned WORDS = SIZE_BYTES / 4;
    localparam int unsigned AW    = $clog2(SIZE_BYTES);
    localparam int unsigned IW    = AW - 2;

    typedef enum logic {StIdle, StClear} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   clr_idx_q, clr_idx_d;
    logic [31:0]     mem_q [WORDS];

    logic [IW-1:0]   widx, ridx;
    logic            wr_acc, rd_acc;
    logic [31:0]     rd_word;

    logic [READ_LATENCY-1:0] vld_q;
    logic [READ_LATENCY-1:0] mis_q;
    logic [31:0]             data_q [READ_LATENCY];

    logic unused_addr;
    assign unused_addr = ^{read_addr_i[31:AW], write_addr_i[31:AW], write_addr_i[1:0]};

    assign widx         = write_addr_i[AW-1:2];
    assign ridx         = read_addr_i[AW-1:2];
    assign busy_o       = (state_q == StClear);
    assign read_ready_o = !busy_o;
    assign wr_acc       = write_enable_i && !busy_o;
    assign rd_acc       = read_req_i && read_ready_o;

    // Clear engine
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req_i) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                end
            end
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IW'(WORDS - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Array is never reset; a reset edge only blocks the writes presented with it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (busy_o) begin
                mem_q[clr_idx_q] <= FILL_WORD;
            end else if (wr_acc) begin
                for (int k = 0; k < 4; k++) begin
                    if (write_be_i[k]) begin
                        mem_q[widx][8*k +: 8] <= write_data_i[8*k +: 8];
                    end
                end
            end
        end
    end

    // Write-first bypass: enabled lanes of a same-word write replace the old bytes.
    always_comb begin
        rd_word = mem_q[ridx];
        for (int k = 0; k < 4; k++) begin
            if (wr_acc && (widx == ridx) && write_be_i[k]) begin
                rd_word[8*k +: 8] = write_data_i[8*k +: 8];
            end
        end
    end

    // Data/misalign stages load only behind a valid bit, so the outputs hold between pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            mis_q <= '0;
            for (int s = 0; s < int'(READ_LATENCY); s++) begin
                data_q[s] <= '0;
            end
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) begin
                data_q[0] <= rd_word;
                mis_q[0]  <= |read_addr_i[1:0];
            end
            for (int s = 1; s < int'(READ_LATENCY); s++) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                    mis_q[s]  <= mis_q[s-1];
                end
            end
        end
    end

    assign read_valid_o    = vld_q[READ_LATENCY-1];
    assign read_data_o     = data_q[READ_LATENCY-1];
    assign read_misalign_o = mis_q[READ_LATENCY-1];

endmodule

// File: tb/tb_rw_instr_mem_pipe.sv
// Bench for rw_instr_mem_pipe: directed vector table, hand-written clear/reset
// sequences and random traffic checked cycle by cycle against a reference model.
module tb_rw_instr_mem_pipe;

    localparam int unsigned SB    = 64;
    localparam int unsigned RL    = 3;
    localparam int unsigned WORDS = SB / 4;
    localparam logic [31:0] FILL  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rreq = 1'b0;
    logic [31:0] raddr = '0;
    logic        we = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        clr = 1'b0;

    logic        read_ready_o, read_valid_o, read_misalign_o, busy_o;
    logic [31:0] read_data_o;

    always #5 clk = ~clk;

    rw_instr_mem_pipe #(
        .SIZE_BYTES  (SB),
        .READ_LATENCY(RL),
        .FILL_WORD   (FILL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .read_req_i     (rreq),
        .read_addr_i    (raddr),
        .read_ready_o   (read_ready_o),
        .read_data_o    (read_data_o),
        .read_valid_o   (read_valid_o),
        .read_misalign_o(read_misalign_o),
        .write_enable_i (we),
        .write_addr_i   (waddr),
        .write_data_i   (wdata),
        .write_be_i     (be),
        .clear_req_i    (clr),
        .busy_o         (busy_o)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference model: word array, busy window from clear start, queue of pending reads.
    typedef struct {
        int          due;
        logic [31:0] data;
        logic        mis;
    } rd_t;

    logic [31:0] m_mem [WORDS];
    rd_t         m_q [$];
    int          edge_n = 0;
    int          m_clr_start = 0;
    bit          m_busy = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = '0;
    logic        exp_mis = 1'b0;

    function automatic int word_of(input logic [31:0] a);
        return int'((a % SB) / 4);
    endfunction

    task automatic model_edge();
        int          idx;
        logic [31:0] wv;
        rd_t         e;
        edge_n++;
        exp_valid = 1'b0;
        if (rst) begin
            m_q.delete();
            m_busy   = 1'b0;
            exp_data = '0;
            exp_mis  = 1'b0;
        end else begin
            if (m_busy) begin
                idx = edge_n - m_clr_start - 1;
                m_mem[idx] = FILL;
                if (idx == int'(WORDS) - 1) m_busy = 1'b0;
            end else begin
                if (we) begin
                    wv = m_mem[word_of(waddr)];
                    for (int k = 0; k < 4; k++) begin
                        if (be[k]) wv[8*k +: 8] = wdata[8*k +: 8];
                    end
                    m_mem[word_of(waddr)] = wv;
                end
                if (rreq) begin
                    e.due  = edge_n + int'(RL) - 1;
                    e.data = m_mem[word_of(raddr)];
                    e.mis  = (raddr % 4) != 0;
                    m_q.push_back(e);
                end
                if (clr) begin
                    m_busy      = 1'b1;
                    m_clr_start = edge_n;
                end
            end
            if (m_q.size() > 0 && m_q[0].due == edge_n) begin
                e = m_q.pop_front();
                exp_valid = 1'b1;
                exp_data  = e.data;
                exp_mis   = e.mis;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk1("sb_busy", busy_o, m_busy);
            chk1("sb_ready", read_ready_o, !m_busy);
            chk1("sb_valid", read_valid_o, exp_valid);
            if (exp_valid) begin
                chk32("sb_data", read_data_o, exp_data);
                chk1("sb_misalign", read_misalign_o, exp_mis);
            end
        end
    end

    task automatic drive(input logic r, input logic rq, input logic [31:0] ra, input logic w,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] b,
                         input logic c);
        @(negedge clk);
        rst = r; rreq = rq; raddr = ra; we = w; waddr = wa; wdata = wd; be = b; clr = c;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        drive(1'b0, 1'b0, '0, 1'b1, a, d, b, 1'b0);
    endtask

    // Issue one read (optionally with a same-cycle write) and check the returned pulse.
    task automatic rd_chk(input string name, input logic [31:0] ra, input logic w,
                          input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] b,
                          input logic [31:0] exp_d, input logic exp_m);
        bit          got = 1'b0;
        int          lat = 0;
        logic [31:0] d = '0;
        logic        m = 1'b0;
        drive(1'b0, 1'b1, ra, w, wa, wd, b, 1'b0);
        for (int i = 1; i <= 8 && !got; i++) begin
            idle();
            if (read_valid_o) begin
                got = 1'b1;
                lat = i;
                d   = read_data_o;
                m   = read_misalign_o;
            end
        end
        chk1({name, "_arrived"}, got, 1'b1);
        if (got) begin
            chk32({name, "_data"}, d, exp_d);
            chk1({name, "_misalign"}, m, exp_m);
            chk32({name, "_latency"}, lat, RL);
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [3:0]  b;
        logic [31:0] ra;
        logic [31:0] exp_d;
        logic        exp_m;
        string       name;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int          n;
        int          first;
        int          last;
        bit          seen;
        logic [31:0] got_d [$];

        tbl[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, "aligned"};
        tbl[1] = '{1'b0, 32'h0,  32'h0,         4'h0, 32'h12, 32'hDEAD_BEEF, 1'b1, "misalign"};
        tbl[2] = '{1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h20, 32'h1122_3344, 1'b0, "full_wr"};
        tbl[3] = '{1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 32'h20, 32'h11BB_33DD, 1'b0, "be_0101"};
        tbl[4] = '{1'b1, 32'h20, 32'h0,         4'h0, 32'h23, 32'h11BB_33DD, 1'b1, "be_zero"};
        tbl[5] = '{1'b1, 32'h44, 32'h7,         4'hF, 32'h04, 32'h7,         1'b0, "wrap"};
        tbl[6] = '{1'b1, 32'h7C, 32'h0BAD_F00D, 4'hF, 32'h3D, 32'h0BAD_F00D, 1'b1, "wrap_hi"};
        tbl[7] = '{1'b0, 32'h0,  32'h0,         4'h0, 32'h14, FILL,          1'b0, "drop_busy"};

        // Reset values
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk32("rst_data", read_data_o, 32'h0);
        chk1("rst_misalign", read_misalign_o, 1'b0);
        chk1("rst_valid", read_valid_o, 1'b0);
        chk1("rst_busy", busy_o, 1'b0);
        idle();
        chk1("rst_ready", read_ready_o, 1'b1);

        // Clear with a same-cycle write (overwritten), a dropped write and a repeated request
        drive(1'b0, 1'b0, '0, 1'b1, 32'h18, 32'h6666_6666, 4'hF, 1'b1);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == 3) drive(1'b0, 1'b0, '0, 1'b1, 32'h14, 32'hBAD0_BAD0, 4'hF, 1'b1);
            else idle();
            if (busy_o) n++;
            else if (n > 0) break;
        end
        chk32("clear_busy_cycles", n, WORDS);
        rd_chk("clear_overwrites", 32'h18, 1'b0, '0, '0, 4'h0, FILL, 1'b0);
        for (int i = 0; i < int'(WORDS); i += 5) begin
            rd_chk("clear_fill", 32'(i * 4), 1'b0, '0, '0, 4'h0, FILL, 1'b0);
        end

        // Directed table
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].w) wr(tbl[i].wa, tbl[i].wd, tbl[i].b);
            rd_chk(tbl[i].name, tbl[i].ra, 1'b0, '0, '0, 4'h0, tbl[i].exp_d, tbl[i].exp_m);
        end

        // Same-edge read/write hazard
        wr(32'h30, 32'h0, 4'hF);
        rd_chk("hazard", 32'h30, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'h3, 32'h0000_FFFF, 1'b0);
        rd_chk("hazard_after", 32'h30, 1'b0, '0, '0, 4'h0, 32'h0000_FFFF, 1'b0);

        // Back-to-back reads give consecutive pulses in order
        wr(32'h0, 32'hA0, 4'hF);
        wr(32'h8, 32'hA2, 4'hF);
        first = -1;
        last  = -1;
        got_d.delete();
        for (int i = 0; i < 12; i++) begin
            if (i < 3) drive(1'b0, 1'b1, 32'(i * 4), 1'b0, '0, '0, 4'h0, 1'b0);
            else idle();
            if (read_valid_o) begin
                if (first < 0) first = i;
                last = i;
                got_d.push_back(read_data_o);
            end
        end
        chk32("b2b_count", got_d.size(), 3);
        chk32("b2b_first", first, RL);
        chk32("b2b_span", last - first, 2);
        if (got_d.size() == 3) begin
            chk32("b2b_d0", got_d[0], 32'hA0);
            chk32("b2b_d1", got_d[1], 32'h7);
            chk32("b2b_d2", got_d[2], 32'hA2);
        end

        // Reset on the fifth busy cycle aborts the clear
        for (int i = 0; i < 4; i++) wr(32'(i * 4), 32'hC0 + 32'(i), 4'hF);
        wr(32'h14, 32'h5555_5555, 4'hF);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 4'h0, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (busy_o) n++;
            if (n == 5) break;
        end
        chk32("abort_busy_seen", n, 5);
        rst = 1'b1;
        idle();
        chk1("abort_busy_low", busy_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rd_chk("abort_filled", 32'(i * 4), 1'b0, '0, '0, 4'h0, FILL, 1'b0);
        end
        rd_chk("abort_kept", 32'h14, 1'b0, '0, '0, 4'h0, 32'h5555_5555, 1'b0);

        // Reset with a read in flight; write and read in the reset cycle are ignored
        drive(1'b0, 1'b1, 32'h14, 1'b0, '0, '0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, 32'h1C, 1'b1, 32'h1C, 32'h7777_7777, 4'hF, 1'b0);
        idle();
        chk32("flush_data_zero", read_data_o, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (read_valid_o) seen = 1'b1;
        end
        chk1("flush_no_pulse", seen, 1'b0);
        rd_chk("rst_write_ignored", 32'h1C, 1'b0, '0, '0, 4'h0, FILL, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            drive(($urandom % 80) == 0, 1'($urandom), ra, 1'($urandom),
                  (($urandom % 3) == 0) ? ra : $urandom, $urandom, 4'($urandom),
                  ($urandom % 50) == 0);
        end
        repeat (WORDS + 8) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rw_instr_mem_pipe.md
Name: rw_instr_mem_pipe

Overview:
Parametrised read/write instruction memory, the next generation of the core's instruction store. Adds:
- byte-enabled writes;
- a registered read path with configurable latency and valid tagging;
- write-first same-cycle bypass;
- a misalignment flag;
- a hardware clear engine that fills the array with a NOP word.

Sits between the fetch stage (read port) and the program loader / debug writer (write port).

Parameters:
SIZE_BYTES, 1024, array size in bytes; power of two, >= 16; WORDS = SIZE_BYTES/4.
READ_LATENCY, 1, clock edges from accepted read request to read_valid_o; legal range 1..4.
FILL_WORD, 32'h0000_0013, word written to every location by the clear engine (RV32I NOP).

Ports:
clk_i  input  1  clock; all state changes on its rising edge.
rst_i  input  1  reset; synchronous, active-high.
read_req_i  input  1  read request; accepted when read_ready_o is high.
read_addr_i  input  32  byte address of the read.
read_ready_o  output  1  read port can accept a request; equals !busy_o.
read_data_o  output  32  read data; qualified by read_valid_o.
read_valid_o  output  1  one-cycle pulse per accepted read.
read_misalign_o  output  1  read_addr_i[1:0] != 0 for the returned word; qualified by read_valid_o.
write_enable_i  input  1  write strobe.
write_addr_i  input  32  byte address of the write.
write_data_i  input  32  write data.
write_be_i  input  4  byte enables; bit k selects byte lane [8k+7:8k].
clear_req_i  input  1  start-clear pulse.
busy_o  output  1  clear engine active.

Behaviour:
- Word index = addr[$clog2(SIZE_BYTES)-1:2]. Upper address bits are ignored, so addresses wrap modulo SIZE_BYTES. Bits [1:0] are ignored for indexing.
- Write:
  - Performed at the edge when write_enable_i=1 and busy_o=0; only lanes with write_be_i[k]=1 are updated.
  - write_be_i=0 is a no-op.
  - Writes while busy_o=1 are dropped silently.
- Read acceptance: read_req_i && read_ready_o at edge N.
  - Stage 1 samples the array and is registered at edge N.
  - READ_LATENCY-1 further register stages follow.
  - read_valid_o, read_data_o and read_misalign_o are asserted after edge N+READ_LATENCY-1, for exactly one cycle per request.
  - READ_LATENCY=1 means data is visible in the cycle after the request.
- Throughput: one read accepted per cycle; back-to-back requests produce back-to-back valid pulses in request order.
- Same-cycle hazard (read and write accepted at the same edge, same word index): returned data is the merged result. Lanes with write_be_i=1 take the new bytes; other lanes take the old contents (write-first).
- Between valid pulses, read_data_o holds its last value. It is not checked by the bench.
- Clear engine FSM:
  - States IDLE and CLEAR.
  - IDLE -> CLEAR on clear_req_i=1; busy_o goes high the next cycle and the index counter is loaded with 0.
  - In CLEAR, one word is written with FILL_WORD per cycle, at indices 0..WORDS-1 in order.
  - After the edge that writes index WORDS-1, the FSM returns to IDLE and busy_o=0.
  - A clear therefore occupies exactly WORDS cycles with busy_o=1.
  - clear_req_i in CLEAR is ignored.
  - clear_req_i together with write_enable_i in IDLE: the write is performed, then the clear overwrites it.
- Reads during clear:
  - read_ready_o=0, so no requests are accepted.
  - Reads accepted before busy_o rose still complete through the pipeline. Their data is what the array held at their acceptance edge.
- Reset (rst_i=1 at an edge):
  - FSM -> IDLE; clear counter = 0.
  - busy_o=0, read_ready_o=1 (after reset deasserts), read_valid_o=0, read_misalign_o=0, read_data_o=0.
  - All pipeline valid bits are cleared; in-flight reads are discarded and produce no pulse.
  - A reset mid-clear aborts the clear; the partially filled contents remain.
  - Array contents are not reset.
  - Writes and read requests presented in a reset cycle are ignored.

Test Plan:
1. READ_LATENCY=2: write 32'hDEAD_BEEF at 0x10 (be=4'hF); read 0x10 at edge N -> read_valid_o high after edge N+1, data DEADBEEF, read_misalign_o=0; read 0x12 -> same data, read_misalign_o=1.
2. Byte enables: word 0x20 = 32'h1122_3344; write 32'hAABB_CCDD with be=4'b0101 -> readback 32'h11BB_33DD; be=0 write leaves it unchanged.
3. Hazard: word 0x30 = 0; same edge read 0x30 + write 32'hFFFF_FFFF be=4'b0011 -> returned data 32'h0000_FFFF; following read also 32'h0000_FFFF.
4. Wrap and throughput: SIZE_BYTES=1024; write 7 at 0x404 -> read 0x004 returns 7; reads of 0x0,0x4,0x8 on consecutive cycles -> three consecutive valid pulses, in order.
5. Clear: SIZE_BYTES=64; clear_req_i pulse -> busy_o high 16 cycles, read_ready_o low over the same span, write during clear dropped; afterwards every word reads 32'h0000_0013.
6. Reset: assert rst_i on cycle 5 of a clear with a read in flight (READ_LATENCY=3) -> busy_o=0, no read_valid_o pulse; words 0..3 are 0x13, word 5 keeps its old value.
